// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue feeding the IF/ID register.
// Owns the fetch PC, tracks in-flight requests and flushes on redirect.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        ifid_stall,
  output logic        inst_valid,
  output logic [15:0] inst_out,
  output logic [15:0] pc_added_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  logic [15:0]   pc;
  logic [15:0]   fifo_inst [DEPTH];
  logic [15:0]   fifo_pca  [DEPTH];
  logic [15:0]   tag_q     [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] tag_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] stale;
  logic [CW-1:0] inflight_next;
  logic [CW:0]   occupancy;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;

  // Credit: buffered plus outstanding never exceeds the FIFO size.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign imem_req  = !rst && !redirect && (occupancy < FULL);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign drop = (stale != '0) || redirect;
  assign push = imem_rvalid && !drop;
  assign pop  = inst_valid && !ifid_stall && !redirect;

  assign inflight_next = inflight + CW'(grant) - CW'(imem_rvalid);

  assign inst_valid   = (count != '0);
  assign inst_out     = inst_valid ? fifo_inst[rd_ptr] : NOP_INST;
  assign pc_added_out = inst_valid ? fifo_pca[rd_ptr] : 16'h0000;

  // Control state: pc, pointers, occupancy and discard bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      inflight <= '0;
      stale    <= '0;
    end else begin
      inflight <= inflight_next;
      if (grant) begin
        pc     <= pc + 16'd1;
        tag_wr <= tag_wr + AW'(1);
      end
      if (imem_rvalid) begin
        tag_rd <= tag_rd + AW'(1);
      end
      if (redirect) begin
        pc     <= redirect_target;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        stale  <= inflight_next;
      end else begin
        if (imem_rvalid && stale != '0) begin
          stale <= stale - CW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage: tag captured at grant, entry written on accepted data.
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_q[tag_wr] <= pc + 16'd1;
    end
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rdata;
      fifo_pca[wr_ptr]  <= tag_q[tag_rd];
    end
  end

  a_credit: assert property (
    @(posedge clk) disable iff (rst) occupancy <= FULL);
  a_stale: assert property (
    @(posedge clk) disable iff (rst) stale <= inflight);
  a_rvalid: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> inflight != '0);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus random traffic
// checked against an in-order address scoreboard.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        ifid_stall;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] pc_added_out;

  logic        w_req;
  logic [15:0] w_addr;
  logic        w_valid;
  logic [15:0] w_inst;
  logic [15:0] w_pca;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int ecount = 0;

  logic [15:0] mq_addr [$];
  int          mq_due  [$];

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_target(redirect_target), .ifid_stall(ifid_stall),
    .inst_valid(inst_valid), .inst_out(inst_out),
    .pc_added_out(pc_added_out)
  );

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_target(redirect_target), .ifid_stall(ifid_stall),
    .inst_valid(w_valid), .inst_out(w_inst),
    .pc_added_out(w_pca)
  );

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory model: record grants, retire responses.
  always @(negedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_rvalid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(ecount + 1 + lat);
      end
    end
  end

  // Memory model: present the oldest due response.
  always @(posedge clk) begin
    ecount++;
    #1;
    if (!rst && mq_addr.size() > 0 && mq_due[0] <= ecount + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%b want=0", imem_req);
    end
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b want=0", inst_valid);
    end
    total++;
    if (inst_out !== 16'h0000) begin
      bad++; $display("FAIL rst_inst got=%h want=0000", inst_out);
    end
    total++;
    if (pc_added_out !== 16'h0000) begin
      bad++; $display("FAIL rst_pca got=%h want=0000", pc_added_out);
    end
    total++;
    if (imem_addr !== 16'h0000) begin
      bad++; $display("FAIL rst_addr got=%h want=0000", imem_addr);
    end
    total++;
    if (w_addr !== 16'hFFFE || w_req !== 1'b0 || w_inst !== 16'h0000) begin
      bad++;
      $display("FAIL rst_w got=%h/%b/%h want=fffe/0/0000",
               w_addr, w_req, w_inst);
    end
  endtask

  task automatic test_stream();
    lat = 1; imem_gnt = 1'b1; ifid_stall = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(c)) begin
        bad++;
        $display("FAIL stream_req c=%0d got=%b/%h want=1/%h",
                 c, imem_req, imem_addr, 16'(c));
      end
      total++;
      if (inst_valid !== (c >= 2)) begin
        bad++;
        $display("FAIL stream_valid c=%0d got=%b want=%b",
                 c, inst_valid, c >= 2);
      end
      if (c >= 2) begin
        total++;
        if (pc_added_out !== 16'(c - 1) ||
            inst_out !== word_of(16'(c - 2))) begin
          bad++;
          $display("FAIL stream_data c=%0d got=%h/%h want=%h/%h", c,
                   pc_added_out, inst_out, 16'(c - 1), word_of(16'(c - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    lat = 1; imem_gnt = 1'b1; ifid_stall = 1'b1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) reqs++;
      if (inst_valid) begin
        total++;
        if (inst_out !== word_of(16'h0000)) begin
          bad++;
          $display("FAIL stall_head c=%0d got=%h want=%h",
                   c, inst_out, word_of(16'h0000));
        end
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (reqs !== 4) begin
      bad++; $display("FAIL stall_reqs got=%0d want=4", reqs);
    end
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 ||
        pc_added_out !== 16'h0001) begin
      bad++;
      $display("FAIL stall_hold got=%b/%b/%h want=0/1/0001",
               imem_req, inst_valid, pc_added_out);
    end
    tick();
    ifid_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (inst_valid !== 1'b1 || pc_added_out !== 16'(i + 1) ||
          inst_out !== word_of(16'(i))) begin
        bad++;
        $display("FAIL stall_drain i=%0d got=%b/%h/%h want=1/%h/%h", i,
                 inst_valid, pc_added_out, inst_out,
                 16'(i + 1), word_of(16'(i)));
      end
      tick();
    end
  endtask

  task automatic test_redirect_lat3();
    lat = 3; imem_gnt = 1'b1; ifid_stall = 1'b0;
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1;
    redirect_target = 16'h0040;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL rd3_req got=%b want=0", imem_req);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if (imem_addr !== 16'h0040) begin
      bad++; $display("FAIL rd3_addr got=%h want=0040", imem_addr);
    end
    for (int c = 4; c < 9; c++) begin
      if (c > 4) @(negedge clk);
      total++;
      if (inst_valid !== (c == 8)) begin
        bad++;
        $display("FAIL rd3_valid c=%0d got=%b want=%b",
                 c, inst_valid, c == 8);
      end
      if (c == 8) begin
        total++;
        if (pc_added_out !== 16'h0041 ||
            inst_out !== word_of(16'h0040)) begin
          bad++;
          $display("FAIL rd3_first got=%h/%h want=0041/%h",
                   pc_added_out, inst_out, word_of(16'h0040));
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_rvalid();
    lat = 1; imem_gnt = 1'b1; ifid_stall = 1'b1;
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1;
    redirect_target = 16'h0080;
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b1 || pc_added_out !== 16'h0001) begin
      bad++;
      $display("FAIL rdv_pre got=%b/%h want=1/0001",
               inst_valid, pc_added_out);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0 || imem_addr !== 16'h0080 ||
        imem_req !== 1'b1) begin
      bad++;
      $display("FAIL rdv_next got=%b/%h/%b want=0/0080/1",
               inst_valid, imem_addr, imem_req);
    end
    tick();
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL rdv_gap got=%b want=0", inst_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b1 || pc_added_out !== 16'h0081 ||
        inst_out !== word_of(16'h0080)) begin
      bad++;
      $display("FAIL rdv_first got=%b/%h/%h want=1/0081/%h", inst_valid,
               pc_added_out, inst_out, word_of(16'h0080));
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ea;
    logic [15:0] ep;
    lat = 1; imem_gnt = 1'b1; ifid_stall = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ea = 16'hFFFE + 16'(c);
      ep = 16'hFFFF + 16'(c - 2);
      if (c < 3) begin
        total++;
        if (w_addr !== ea) begin
          bad++;
          $display("FAIL wrap_addr c=%0d got=%h want=%h", c, w_addr, ea);
        end
      end
      if (c >= 2) begin
        total++;
        if (w_valid !== 1'b1 || w_pca !== ep) begin
          bad++;
          $display("FAIL wrap_pca c=%0d got=%b/%h want=1/%h",
                   c, w_valid, w_pca, ep);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    lat = 1; imem_gnt = 1'b1; ifid_stall = 1'b1;
    do_reset();
    tick(); tick(); tick(); tick();
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rmid_pre got=%b/%b want=1/0", inst_valid, imem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0 || imem_addr !== 16'h0000 ||
        imem_req !== 1'b1 || inst_out !== 16'h0000) begin
      bad++;
      $display("FAIL rmid_next got=%b/%h/%b/%h want=0/0000/1/0000",
               inst_valid, imem_addr, imem_req, inst_out);
    end
    total++;
    if (w_addr !== 16'hFFFE || w_req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_w got=%h/%b want=fffe/1", w_addr, w_req);
    end
    tick();
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_gap got=%b want=0", inst_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b1 || pc_added_out !== 16'h0001 ||
        inst_out !== word_of(16'h0000)) begin
      bad++;
      $display("FAIL rmid_first got=%b/%h/%h want=1/0001/%h",
               inst_valid, pc_added_out, inst_out, word_of(16'h0000));
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_q [$];
    logic [15:0] mpc;
    logic [15:0] e;
    int pops;
    for (int seg = 0; seg < 3; seg++) begin
      lat = seg + 1; imem_gnt = 1'b1; ifid_stall = 1'b0;
      do_reset();
      exp_q.delete();
      mpc = 16'h0000;
      pops = 0;
      for (int c = 0; c < 300; c++) begin
        imem_gnt   = ($urandom_range(0, 9) < 7);
        ifid_stall = ($urandom_range(0, 3) == 0);
        redirect   = !redirect && ($urandom_range(0, 19) == 0);
        redirect_target = 16'($urandom);
        @(negedge clk);
        total++;
        if (imem_addr !== mpc) begin
          bad++;
          $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr, mpc);
        end
        if (redirect) begin
          total++;
          if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rnd_req c=%0d got=%b want=0", c, imem_req);
          end
        end
        if (!inst_valid) begin
          total++;
          if (inst_out !== 16'h0000 || pc_added_out !== 16'h0000) begin
            bad++;
            $display("FAIL rnd_empty c=%0d got=%h/%h want=0000/0000",
                     c, inst_out, pc_added_out);
          end
        end
        if (inst_valid && !ifid_stall && !redirect) begin
          total++;
          pops++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rnd_extra c=%0d got=%h want=none",
                     c, pc_added_out);
          end else begin
            e = exp_q.pop_front();
            if (pc_added_out !== e + 16'd1 || inst_out !== word_of(e)) begin
              bad++;
              $display("FAIL rnd_data c=%0d got=%h/%h want=%h/%h", c,
                       pc_added_out, inst_out, e + 16'd1, word_of(e));
            end
          end
        end
        if (redirect) begin
          exp_q.delete();
          mpc = redirect_target;
        end else if (imem_req && imem_gnt) begin
          exp_q.push_back(mpc);
          mpc = mpc + 16'd1;
        end
        tick();
      end
      redirect = 1'b0;
      total++;
      if (pops < 30) begin
        bad++; $display("FAIL rnd_rate seg=%0d got=%0d want>=30", seg, pops);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 16'h0000;
    redirect = 1'b0;
    redirect_target = 16'h0000;
    ifid_stall = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_lat3();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
